// File: rtl/zigzag_pkg.sv
// Shared constants for the zigzag reorder sequencer: block geometry and the
// zigzag-index to raster-address table.
package zigzag_pkg;

  localparam int BLK_SZ = 64;
  localparam int IDX_W  = 6;
  localparam int NBANK  = 2;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = 6'd63;

  localparam idx_t ZZ_LUT [0:BLK_SZ-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic idx_t zz_map(input idx_t idx);
    return ZZ_LUT[idx];
  endfunction

endpackage

// File: rtl/zigzag_ctrl.sv
// Ping-pong bank sequencer: raster-order writes from the FDCT, zigzag-order
// reads to the quantiser. Addressing and handshake only.
module zigzag_ctrl
  import zigzag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_strb,
  output logic       in_ready,
  output logic       wr_en,
  output logic       wr_bank,
  output logic [5:0] wr_addr,
  output logic       rd_en,
  output logic       rd_bank,
  output logic [5:0] rd_addr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_strb,
  output logic       out_last,
  output logic       sync_err
);

  idx_t       r_wr_cnt;
  idx_t       r_rd_idx;
  logic       r_wb;
  logic       r_rb;
  logic [1:0] r_full;
  logic       r_synced;
  logic       r_out_valid;
  logic       r_out_strb;
  logic       r_out_last;

  logic       w_take;
  logic       w_accept;
  logic       w_wr_done;
  logic       w_rd_done;
  logic       w_adv;
  logic [1:0] w_full_set;
  logic [1:0] w_full_clr;

  assign in_ready  = ~r_full[r_wb];
  assign w_take    = in_valid & in_ready;
  // Unsynchronised words are dropped; a strobe always resynchronises.
  assign w_accept  = w_take & (in_strb | r_synced);
  assign sync_err  = w_take & ((in_strb & (r_wr_cnt != 6'd0)) | (~in_strb & ~r_synced));
  assign w_wr_done = w_accept & ~in_strb & (r_wr_cnt == LAST_IDX);

  assign wr_en   = w_accept;
  assign wr_bank = r_wb;
  assign wr_addr = in_strb ? 6'd0 : r_wr_cnt;

  assign w_adv     = ~r_out_valid | out_ready;
  assign rd_en     = r_full[r_rb] & w_adv;
  assign w_rd_done = rd_en & (r_rd_idx == LAST_IDX);
  assign rd_bank   = r_rb;
  assign rd_addr   = zz_map(r_rd_idx);

  assign out_valid = r_out_valid;
  assign out_strb  = r_out_strb;
  assign out_last  = r_out_last;

  // Set and clear always target different banks, so both can apply together.
  assign w_full_set = {w_wr_done & r_wb, w_wr_done & ~r_wb};
  assign w_full_clr = {w_rd_done & r_rb, w_rd_done & ~r_rb};

  // Bank-full flags shared by the write and read sides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Write counter, write bank and framing state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt <= 6'd0;
      r_wb     <= 1'b0;
      r_synced <= 1'b0;
    end else if (w_accept) begin
      if (in_strb) begin
        r_synced <= 1'b1;
        r_wr_cnt <= 6'd1;
      end else if (r_wr_cnt == LAST_IDX) begin
        r_synced <= 1'b0;
        r_wr_cnt <= 6'd0;
        r_wb     <= ~r_wb;
      end else begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
      end
    end
  end

  // Read index, read bank and the registered output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_idx    <= 6'd0;
      r_rb        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_strb  <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (rd_en) begin
        if (r_rd_idx == LAST_IDX) begin
          r_rd_idx <= 6'd0;
          r_rb     <= ~r_rb;
        end else begin
          r_rd_idx <= r_rd_idx + 6'd1;
        end
      end
      if (w_adv) begin
        r_out_valid <= rd_en;
        r_out_strb  <= rd_en & (r_rd_idx == 6'd0);
        r_out_last  <= rd_en & (r_rd_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_zigzag_ctrl.sv
// Directed bench for zigzag_ctrl: table-driven streaming vectors plus
// hand-written stall, framing and mid-block reset sequences.
module tb_zigzag_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_strb, in_ready, wr_en, wr_bank;
  logic [5:0] wr_addr;
  logic       rd_en, rd_bank;
  logic [5:0] rd_addr;
  logic       out_valid, out_ready, out_strb, out_last, sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] zz [64];

  typedef struct {
    logic        rst_first;
    logic        iv;
    logic        is;
    logic        ordy;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  zigzag_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_strb(in_strb),
    .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_strb(out_strb), .out_last(out_last),
    .sync_err(sync_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_strb   = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cyc(input logic iv, input logic is, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_strb   = is;
    out_ready = ordy;
    #1;
  endtask

  // Expected per-cycle outputs for nblk back-to-back blocks at full rate.
  task automatic fill_stream(input int nblk);
    int ncyc;
    ncyc = 64 * nblk + 66;
    for (int c = 0; c < ncyc; c++) begin
      vec_t v;
      logic wp, rp, ov;
      logic e_wb, e_rb;
      logic [5:0] e_wa, e_ra;
      int k;
      int k2;
      wp = (c < 64 * nblk);
      rp = (c >= 64) && (c < 64 + 64 * nblk);
      ov = (c >= 65) && (c <= 64 + 64 * nblk);
      k  = (c - 64) % 64;
      k2 = (c - 65) % 64;
      e_wa = wp ? 6'(c % 64) : 6'd0;
      e_wb = wp ? 1'((c / 64) % 2) : 1'(nblk % 2);
      e_ra = rp ? zz[k] : zz[0];
      e_rb = (c < 64) ? 1'b0 : (rp ? 1'(((c - 64) / 64) % 2) : 1'(nblk % 2));
      v.rst_first = (c == 0);
      v.iv   = wp;
      v.is   = wp && (c % 64 == 0);
      v.ordy = 1'b1;
      v.exp  = {1'b1, wp, e_wb, e_wa, rp, e_rb, e_ra, ov,
                ov && (k2 == 0), ov && (k2 == 63), 1'b0};
      vecs.push_back(v);
    end
  endtask

  initial begin
    int n;
    int bad;
    logic seen_rd;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_strb   = 1'b0;
    out_ready = 1'b0;

    // Zigzag reference built by diagonal traversal.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[n] = 6'(r * 8 + (s - r)); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[n] = 6'(r * 8 + (s - r)); n++; end
      end
    end

    fill_stream(1);
    fill_stream(3);

    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_outs", {25'd0, wr_en, rd_en, out_valid, out_strb, out_last, sync_err, wr_bank}, 32'd0);

    // Tests 1 and 2: single block and three back-to-back blocks.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) do_reset();
      cyc(vecs[i].iv, vecs[i].is, vecs[i].ordy);
      chk($sformatf("stream_vec%0d", i),
          {11'd0, in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           out_valid, out_strb, out_last, sync_err},
          {11'd0, vecs[i].exp});
    end

    // Test 3: long output stall, both banks fill, then drain.
    do_reset();
    for (int c = 0; c < 128; c++) begin
      cyc(1'b1, (c % 64) == 0, 1'b0);
      if (c == 65) begin
        chk("t3_held_first", {28'd0, out_valid, out_strb, rd_en, in_ready}, {28'd0, 4'b1101});
        chk("t3_held_addr", {26'd0, rd_addr}, {26'd0, zz[1]});
      end
    end
    bad = 0;
    for (int c = 128; c < 200; c++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (in_ready !== 1'b0 || wr_en !== 1'b0 || sync_err !== 1'b0 ||
          out_valid !== 1'b1 || out_strb !== 1'b1 || rd_en !== 1'b0 || rd_addr !== zz[1])
        bad++;
    end
    chk("t3_stall_cycles_bad", bad, 0);
    n = 0;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (out_valid) begin
        if (out_strb !== ((n % 64) == 0) || out_last !== ((n % 64) == 63)) bad++;
        n++;
      end
    end
    chk("t3_words", n, 128);
    chk("t3_flag_errs", bad, 0);
    chk("t3_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Test 4: stray word before sync, then mid-block re-strobe.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    chk("t4_stray", {29'd0, sync_err, wr_en, in_ready}, {29'd0, 3'b101});
    cyc(1'b0, 1'b0, 1'b1);
    chk("t4_stray_pulse_end", {31'd0, sync_err}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, i == 0, 1'b1);
      if (wr_addr !== 6'(i) || wr_en !== 1'b1 || sync_err !== 1'b0) bad++;
    end
    chk("t4_first20", bad, 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t4_resync", {23'd0, sync_err, wr_en, wr_bank, wr_addr}, {23'd0, 3'b110, 6'd0});
    bad = 0;
    for (int i = 1; i < 64; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (wr_addr !== 6'(i) || wr_en !== 1'b1 || sync_err !== 1'b0 || rd_en !== 1'b0) bad++;
    end
    chk("t4_rest63", bad, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t4_block_full", {29'd0, rd_en, rd_bank, wr_bank}, {29'd0, 3'b101});
    cyc(1'b0, 1'b0, 1'b1);
    chk("t4_first_out", {30'd0, out_valid, out_strb}, {30'd0, 2'b11});

    // Test 5: reset while draining at read index 30.
    do_reset();
    for (int c = 0; c < 64; c++) cyc(1'b1, c == 0, 1'b1);
    for (int k = 0; k <= 30; k++) cyc(1'b0, 1'b0, 1'b1);
    chk("t5_at_idx30", {25'd0, rd_en, rd_addr}, {25'd0, 1'b1, zz[30]});
    rst = 1'b0;
    #1;
    chk("t5_in_reset", {29'd0, out_valid, rd_en, in_ready}, {29'd0, 3'b001});
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (out_valid !== 1'b0 || rd_en !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("t5_idle_after", bad, 0);
    for (int c = 0; c < 64; c++) begin
      cyc(1'b1, c == 0, 1'b1);
      if (c == 0) chk("t5_wr_bank", {31'd0, wr_bank}, 32'd0);
    end
    n = 0;
    bad = 0;
    seen_rd = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (rd_en && !seen_rd) begin
        seen_rd = 1'b1;
        chk("t5_rd_start", {25'd0, rd_bank, rd_addr}, {25'd0, 1'b0, zz[0]});
      end
      if (out_valid) begin
        if (out_strb !== (n == 0) || out_last !== (n == 63)) bad++;
        n++;
      end
    end
    chk("t5_rd_seen", {31'd0, seen_rd}, 32'd1);
    chk("t5_words", n, 64);
    chk("t5_flag_errs", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
